lfsr_checker: RTL

Receive-side companion to the on-chip LFSR pattern generator. Accepts a stream of sampled LFSR states, seeds itself from the first non-zero sample, then predicts each following state using the same right-shift Galois recurrence. It flags mismatches, declares lock and loss-of-lock, and keeps a saturating error count for display or readout. Sits between the sampling front end (one sample per valid strobe) and the status/display logic.

---
 rtl/lfsr_checker_pkg.sv | 24 ++
 rtl/lfsr_checker_errcnt.sv | 19 +
 rtl/lfsr_checker.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared types, defaults and Galois step function for lfsr_checker
package lfsr_checker_pkg;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int DEF_LFSR_BITS    = 5;
   localparam int DEF_LOCK_MATCHES = 4;
   localparam int DEF_LOSS_MISSES  = 3;
   localparam int DEF_ERR_BITS     = 8;
   localparam int LFSR_MAX_BITS    = 32;

   // Right-shift Galois step; callers zero-extend narrower states and taps.
   function automatic logic [LFSR_MAX_BITS-1:0] lfsr_next(
      input logic [LFSR_MAX_BITS-1:0] v,
      input logic [LFSR_MAX_BITS-1:0] taps
   );
      return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
   endfunction

endpackage

// File: rtl/lfsr_checker_errcnt.sv
// rtl/lfsr_checker_errcnt.sv - saturating error counter with increment enable
module lfsr_checker_errcnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - LFSR receive checker: seed, verify, lock, flywheel and error count
// Optional error counter enabled by macro LFSR_CHECKER_ERRCNT_EN.
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int LFSR_BITS    = DEF_LFSR_BITS,
   parameter int LOCK_MATCHES = DEF_LOCK_MATCHES,
   parameter int LOSS_MISSES  = DEF_LOSS_MISSES,
   parameter int ERR_BITS     = DEF_ERR_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_taps,
   input  logic [LFSR_BITS-1:0] tap_in,
   input  logic                 sample_valid,
   input  logic [LFSR_BITS-1:0] sample_in,
   output logic                 locked,
   output logic                 mismatch,
   output logic [LFSR_BITS-1:0] expected,
   output logic [ERR_BITS-1:0]  err_count
);

   localparam int GOOD_W = $clog2(LOCK_MATCHES + 1);
   localparam int BAD_W  = $clog2(LOSS_MISSES + 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_MATCHES - 1);
   localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_MISSES - 1);

   state_t               state;
   logic [LFSR_BITS-1:0] taps;
   logic [GOOD_W-1:0]    good_cnt;
   logic [BAD_W-1:0]     bad_cnt;
   logic [LFSR_BITS-1:0] next_sample;
   logic [LFSR_BITS-1:0] next_expected;
   logic                 hit;
   logic                 sample_zero;

   assign next_sample   = LFSR_BITS'(lfsr_next(LFSR_MAX_BITS'(sample_in), LFSR_MAX_BITS'(taps)));
   assign next_expected = LFSR_BITS'(lfsr_next(LFSR_MAX_BITS'(expected), LFSR_MAX_BITS'(taps)));
   assign hit           = (sample_in == expected);
   assign sample_zero   = (sample_in == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_SEED;
         taps     <= '0;
         good_cnt <= '0;
         bad_cnt  <= '0;
         expected <= '0;
         locked   <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         mismatch <= 1'b0;
         if (load_taps) begin
            // Tap change invalidates any prediction; the coincident sample is dropped.
            taps     <= tap_in;
            state    <= ST_SEED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
         end else if (sample_valid) begin
            case (state)
               ST_SEED: begin
                  if (!sample_zero) begin
                     expected <= next_sample;
                     good_cnt <= '0;
                     state    <= ST_VERIFY;
                  end
               end
               ST_VERIFY: begin
                  if (hit) begin
                     good_cnt <= good_cnt + GOOD_W'(1);
                     expected <= next_expected;
                     if (good_cnt == GOOD_LAST) begin
                        state   <= ST_LOCKED;
                        locked  <= 1'b1;
                        bad_cnt <= '0;
                     end
                  end else begin
                     mismatch <= 1'b1;
                     if (!sample_zero) begin
                        expected <= next_sample;
                        good_cnt <= '0;
                     end else begin
                        state <= ST_SEED;
                     end
                  end
               end
               ST_LOCKED: begin
                  // Flywheel: once locked, the sample never overrides the prediction.
                  expected <= next_expected;
                  if (hit) begin
                     bad_cnt <= '0;
                  end else begin
                     mismatch <= 1'b1;
                     bad_cnt  <= bad_cnt + BAD_W'(1);
                     if (bad_cnt == BAD_LAST) begin
                        state  <= ST_SEED;
                        locked <= 1'b0;
                     end
                  end
               end
               default: begin
                  state  <= ST_SEED;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef LFSR_CHECKER_ERRCNT_EN
   logic err_inc;

   assign err_inc = sample_valid && !load_taps && (state == ST_LOCKED) && !hit;

   lfsr_checker_errcnt #(
      .W (ERR_BITS)
   ) u_errcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc),
      .count (err_count)
   );
`else
   assign err_count = '0;
`endif

endmodule
